// File: rtl/flit_injector.sv
// Packet-to-flit transmitter: serialises a descriptor plus payload words into
// HEAD/BODY/TAIL flits on one round-robin VC, honouring per-VC on/off.
package flit_pkg;
  localparam int VC_NUM            = 2;
  localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DEST_ADDR_SIZE_X  = 2;
  localparam int DEST_ADDR_SIZE_Y  = 2;
  localparam int HEAD_PAYLOAD_SIZE = 12;
  localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module flit_injector
  import flit_pkg::*;
#(
  parameter int BODY_CNT_SIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid_i,
  output logic                         pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic [BODY_CNT_SIZE-1:0]     pkt_body_cnt_i,
  input  logic                         pl_valid_i,
  output logic                         pl_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
  input  logic [VC_NUM-1:0]            on_off_i,
  output flit_t                        data_o,
  output logic                         valid_flit_o,
  output logic                         pkt_sent_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY, ST_TAIL} state_t;

  state_t                   state_q, state_d;
  logic [VC_SIZE-1:0]       rr_ptr_q, rr_ptr_d;
  logic [VC_SIZE-1:0]       cur_vc_q, cur_vc_d;
  logic [BODY_CNT_SIZE-1:0] cnt_q, cnt_d;
  head_data_t               hdr_q, hdr_d;
  flit_t                    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     sent_q, sent_d;

  logic [2*VC_NUM-1:0]      on_dbl;
  logic [VC_NUM-1:0]        on_rot;
  logic                     head_found;
  logic [VC_SIZE-1:0]       head_off;
  logic [VC_SIZE-1:0]       head_vc;
  logic                     pl_fire;

  function automatic logic [VC_SIZE-1:0] vc_add(logic [VC_SIZE-1:0] a, logic [VC_SIZE-1:0] b);
    logic [VC_SIZE:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (VC_SIZE+1)'(VC_NUM)) s = s - (VC_SIZE+1)'(VC_NUM);
    return s[VC_SIZE-1:0];
  endfunction

  // Rotate on/off so bit 0 is the round-robin pointer; lowest set bit wins.
  assign on_dbl = {on_off_i, on_off_i} >> rr_ptr_q;
  assign on_rot = on_dbl[VC_NUM-1:0];

  always_comb begin
    head_found = 1'b0;
    head_off   = '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      if (on_rot[i]) begin
        head_found = 1'b1;
        head_off   = VC_SIZE'(i);
      end
    end
    head_vc = vc_add(rr_ptr_q, head_off);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_vc_d    = cur_vc_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sent_d      = 1'b0;
    pkt_ready_o = 1'b0;
    pl_ready_o  = 1'b0;
    pl_fire     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pkt_ready_o = 1'b1;
        if (pkt_valid_i) begin
          hdr_d.x_dest  = pkt_x_dest_i;
          hdr_d.y_dest  = pkt_y_dest_i;
          hdr_d.head_pl = pkt_head_pl_i;
          cnt_d         = pkt_body_cnt_i;
          state_d       = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (head_found) begin
          valid_d                = 1'b1;
          data_d.flit_label      = HEAD;
          data_d.vc_id           = head_vc;
          data_d.data.head_data  = hdr_q;
          cur_vc_d               = head_vc;
          rr_ptr_d               = vc_add(head_vc, VC_SIZE'(1));
          state_d                = (cnt_q != '0) ? ST_BODY : ST_TAIL;
        end
      end
      ST_BODY, ST_TAIL: begin
        pl_ready_o = on_off_i[cur_vc_q];
        pl_fire    = pl_valid_i & on_off_i[cur_vc_q];
        if (pl_fire) begin
          valid_d           = 1'b1;
          data_d.vc_id      = cur_vc_q;
          data_d.data.bt_pl = pl_data_i;
          if (state_q == ST_BODY) begin
            data_d.flit_label = BODY;
            cnt_d             = cnt_q - 1'b1;
            if (cnt_q == BODY_CNT_SIZE'(1)) state_d = ST_TAIL;
          end else begin
            data_d.flit_label = TAIL;
            sent_d            = 1'b1;
            state_d           = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshakes are masked while reset is held so nothing is accepted then.
    if (rst) begin
      pkt_ready_o = 1'b0;
      pl_ready_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      cur_vc_q <= '0;
      cnt_q    <= '0;
      hdr_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_vc_q <= cur_vc_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sent_q   <= sent_d;
    end
  end

  assign data_o       = data_q;
  assign valid_flit_o = valid_q;
  assign pkt_sent_o   = sent_q;

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: directed scenarios, then random traffic checked
// against a packet-level reference model (descriptor queue, RR rule, word order).
module tb_flit_injector;
  import flit_pkg::*;

  localparam int BCS  = 4;
  localparam int NPKT = 40;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         pkt_valid_i;
  logic                         pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i;
  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i;
  logic [BCS-1:0]               pkt_body_cnt_i;
  logic                         pl_valid_i;
  logic                         pl_ready_o;
  logic [FLIT_DATA_SIZE-1:0]    pl_data_i;
  logic [VC_NUM-1:0]            on_off_i;
  flit_t                        data_o;
  logic                         valid_flit_o;
  logic                         pkt_sent_o;

  flit_injector #(.BODY_CNT_SIZE(BCS)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_x_dest_i(pkt_x_dest_i), .pkt_y_dest_i(pkt_y_dest_i),
    .pkt_head_pl_i(pkt_head_pl_i), .pkt_body_cnt_i(pkt_body_cnt_i),
    .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_data_i(pl_data_i),
    .on_off_i(on_off_i), .data_o(data_o), .valid_flit_o(valid_flit_o),
    .pkt_sent_o(pkt_sent_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DEST_ADDR_SIZE_X-1:0]  x;
    logic [DEST_ADDR_SIZE_Y-1:0]  y;
    logic [HEAD_PAYLOAD_SIZE-1:0] hp;
    int                           cnt;
  } desc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flit(input string tag, input flit_label_t lab, input int vc,
                          input logic [FLIT_DATA_SIZE-1:0] pl, input logic sent);
    chk({tag, "_valid"}, valid_flit_o, 1'b1);
    chk({tag, "_label"}, data_o.flit_label, lab);
    chk({tag, "_vc"}, data_o.vc_id, vc);
    chk({tag, "_data"}, data_o.data.bt_pl, pl);
    chk({tag, "_sent"}, pkt_sent_o, sent);
  endtask

  // Presents a descriptor for one cycle; the DUT must be idle.
  task automatic put_pkt(input int x, input int y, input int hp, input int cnt);
    pkt_x_dest_i   = DEST_ADDR_SIZE_X'(x);
    pkt_y_dest_i   = DEST_ADDR_SIZE_Y'(y);
    pkt_head_pl_i  = HEAD_PAYLOAD_SIZE'(hp);
    pkt_body_cnt_i = BCS'(cnt);
    pkt_valid_i    = 1'b1;
    tick();
    pkt_valid_i    = 1'b0;
  endtask

  function automatic logic [FLIT_DATA_SIZE-1:0] wf(input int w);
    return FLIT_DATA_SIZE'(w * 40503 + 7);
  endfunction

  initial begin
    desc_t             dq[$];
    desc_t             d;
    int                nfl, ncons, m_rr, m_vc, rem, exp_word, sent_words, done, accepted, ev;
    logic              got_tail, hs, hs_pl, hs_pkt, in_pkt, was_in;
    logic [VC_NUM-1:0] prev_on;
    flit_t             last_data;

    rst = 1'b1; pkt_valid_i = 1'b0; pkt_x_dest_i = '0; pkt_y_dest_i = '0;
    pkt_head_pl_i = '0; pkt_body_cnt_i = '0; pl_valid_i = 1'b0; pl_data_i = '0;
    on_off_i = '1;

    // Reset state
    tick();
    chk("rst_pkt_ready", pkt_ready_o, 1'b0);
    chk("rst_valid", valid_flit_o, 1'b0);
    chk("rst_data", data_o, '0);
    chk("rst_sent", pkt_sent_o, 1'b0);
    chk("rst_pl_ready", pl_ready_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_pkt_ready", pkt_ready_o, 1'b1);

    // Single packet, all on: HEAD at accept+2, then one flit per cycle
    pl_valid_i = 1'b1; pl_data_i = 'hA;
    put_pkt(1, 2, 'h123, 2);
    chk("a_wait_valid", valid_flit_o, 1'b0);
    chk("a_busy", pkt_ready_o, 1'b0);
    tick(); chk_flit("a_head", HEAD, 0, {2'd1, 2'd2, 12'h123}, 1'b0);
    chk("a_pl_ready", pl_ready_o, 1'b1);
    tick(); chk_flit("a_b0", BODY, 0, 'hA, 1'b0); pl_data_i = 'hB;
    tick(); chk_flit("a_b1", BODY, 0, 'hB, 1'b0); pl_data_i = 'hC;
    tick(); chk_flit("a_tail", TAIL, 0, 'hC, 1'b1);
    chk("a_idle_ready", pkt_ready_o, 1'b1);
    tick();
    chk("a_after_valid", valid_flit_o, 1'b0);
    chk("a_hold", data_o.data.bt_pl, 'hC);
    chk("a_hold_label", data_o.flit_label, TAIL);
    chk("a_after_sent", pkt_sent_o, 1'b0);

    // body_cnt 0, round-robin moves to VC1
    pl_data_i = 'hD;
    put_pkt(3, 0, 'h0F0, 0);
    tick(); chk_flit("b_head", HEAD, 1, {2'd3, 2'd0, 12'h0F0}, 1'b0);
    tick(); chk_flit("b_tail", TAIL, 1, 'hD, 1'b1);

    // VC0 off at the decision: take VC1, next packet takes VC0
    on_off_i = 2'b10; pl_data_i = 'hE;
    put_pkt(0, 1, 'h005, 0);
    tick(); chk_flit("c_head", HEAD, 1, {2'd0, 2'd1, 12'h005}, 1'b0);
    tick(); chk_flit("c_tail", TAIL, 1, 'hE, 1'b1);
    on_off_i = 2'b11; pl_data_i = 'hF;
    put_pkt(2, 3, 'hABC, 0);
    tick(); chk_flit("c2_head", HEAD, 0, {2'd2, 2'd3, 12'hABC}, 1'b0);
    tick(); chk_flit("c2_tail", TAIL, 0, 'hF, 1'b1);

    // Backpressure on the current VC for 3 cycles; the other VC stays on
    pl_data_i = 'h10;
    put_pkt(1, 1, 'h001, 3);
    tick(); chk_flit("d_head", HEAD, 1, {2'd1, 2'd1, 12'h001}, 1'b0);
    tick(); chk_flit("d_b0", BODY, 1, 'h10, 1'b0);
    on_off_i = 2'b01; pl_data_i = 'h11;
    for (int i = 0; i < 3; i++) begin
      #1 chk("d_pl_ready_off", pl_ready_o, 1'b0);
      tick(); chk("d_stall", valid_flit_o, 1'b0);
    end
    on_off_i = 2'b11;
    tick(); chk_flit("d_b1", BODY, 1, 'h11, 1'b0); pl_data_i = 'h12;
    tick(); chk_flit("d_b2", BODY, 1, 'h12, 1'b0); pl_data_i = 'h13;
    tick(); chk_flit("d_tail", TAIL, 1, 'h13, 1'b1);

    // Payload starvation during TAIL
    pl_data_i = 'h20;
    put_pkt(0, 0, 'h007, 0);
    tick(); chk_flit("e_head", HEAD, 0, {2'd0, 2'd0, 12'h007}, 1'b0);
    pl_valid_i = 1'b0;
    repeat (2) begin
      tick();
      chk("e_starve_valid", valid_flit_o, 1'b0);
      chk("e_starve_busy", pkt_ready_o, 1'b0);
    end
    pl_valid_i = 1'b1;
    tick(); chk_flit("e_tail", TAIL, 0, 'h20, 1'b1);
    chk("e_idle_ready", pkt_ready_o, 1'b1);

    // Maximum body count: 17 flits, 16 payload words
    pl_data_i = 'h100;
    put_pkt(3, 3, 'hFFF, 15);
    nfl = 0; ncons = 0; got_tail = 1'b0;
    for (int i = 0; i < 40 && !got_tail; i++) begin
      hs = pl_valid_i && pl_ready_o;
      tick();
      if (hs) begin ncons++; pl_data_i = pl_data_i + 1'b1; end
      if (valid_flit_o) begin
        nfl++;
        if (data_o.flit_label == TAIL) got_tail = 1'b1;
      end
    end
    chk("f_flits", nfl, 17);
    chk("f_consumed", ncons, 16);
    chk("f_tail_data", data_o.data.bt_pl, 'h10F);
    chk("f_tail_vc", data_o.vc_id, 1);

    // Reset after the HEAD aborts the packet; rr pointer returns to VC0
    put_pkt(1, 0, 'h003, 3);
    tick(); chk_flit("g_head", HEAD, 0, {2'd1, 2'd0, 12'h003}, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("g_valid", valid_flit_o, 1'b0);
    chk("g_data", data_o, '0);
    chk("g_sent", pkt_sent_o, 1'b0);
    chk("g_pl_ready", pl_ready_o, 1'b0);
    chk("g_pkt_ready", pkt_ready_o, 1'b1);
    pl_data_i = 'h30;
    put_pkt(2, 2, 'h004, 0);
    tick(); chk_flit("g2_head", HEAD, 0, {2'd2, 2'd2, 12'h004}, 1'b0);
    tick(); chk_flit("g2_tail", TAIL, 0, 'h30, 1'b1);

    // Random traffic against the packet-level model
    rst = 1'b1; pkt_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    m_rr = 0; m_vc = 0; rem = 0; exp_word = 0; sent_words = 0; done = 0; accepted = 0;
    in_pkt = 1'b0; last_data = data_o;
    for (int cyc = 0; cyc < 20000 && done < NPKT; cyc++) begin
      pkt_valid_i    = (accepted < NPKT) && ($urandom_range(0, 2) == 0);
      pkt_x_dest_i   = DEST_ADDR_SIZE_X'($urandom);
      pkt_y_dest_i   = DEST_ADDR_SIZE_Y'($urandom);
      pkt_head_pl_i  = HEAD_PAYLOAD_SIZE'($urandom);
      pkt_body_cnt_i = ($urandom_range(0, 4) == 0) ? BCS'(15) : BCS'($urandom_range(0, 15));
      pl_valid_i     = ($urandom_range(0, 3) != 0);
      pl_data_i      = wf(sent_words);
      for (int v = 0; v < VC_NUM; v++) on_off_i[v] = ($urandom_range(0, 3) != 0);
      #1;
      chk("r_pkt_ready", pkt_ready_o, !in_pkt && dq.size() == 0);
      chk("r_pl_ready", pl_ready_o, in_pkt ? on_off_i[m_vc] : 1'b0);
      hs_pkt  = pkt_valid_i && pkt_ready_o;
      hs_pl   = pl_valid_i && pl_ready_o;
      prev_on = on_off_i;
      was_in  = in_pkt;
      if (hs_pkt) begin
        d.x = pkt_x_dest_i; d.y = pkt_y_dest_i; d.hp = pkt_head_pl_i;
        d.cnt = int'(pkt_body_cnt_i);
        dq.push_back(d);
        accepted++;
      end
      tick();
      if (hs_pl) sent_words++;
      if (was_in) chk("r_issue", valid_flit_o, hs_pl);
      if (valid_flit_o) begin
        if (!in_pkt) begin
          chk("r_head_pending", dq.size() > 0, 1'b1);
          if (dq.size() > 0) begin
            d  = dq.pop_front();
            ev = -1;
            for (int i = VC_NUM - 1; i >= 0; i--)
              if (prev_on[(m_rr + i) % VC_NUM]) ev = (m_rr + i) % VC_NUM;
            chk("r_head_label", data_o.flit_label, HEAD);
            chk("r_head_vc", data_o.vc_id, ev);
            chk("r_head_data", data_o.data.bt_pl, {d.x, d.y, d.hp});
            chk("r_head_sent", pkt_sent_o, 1'b0);
            m_vc   = int'(data_o.vc_id);
            m_rr   = (m_vc + 1) % VC_NUM;
            rem    = d.cnt;
            in_pkt = 1'b1;
          end
        end else begin
          chk("r_label", data_o.flit_label, (rem > 0) ? BODY : TAIL);
          chk("r_vc", data_o.vc_id, m_vc);
          chk("r_vc_on", prev_on[m_vc], 1'b1);
          chk("r_payload", data_o.data.bt_pl, wf(exp_word));
          chk("r_sent", pkt_sent_o, rem == 0);
          exp_word++;
          if (rem > 0) rem--;
          else begin in_pkt = 1'b0; done++; end
        end
      end else begin
        chk("r_hold", data_o, last_data);
        chk("r_sent_idle", pkt_sent_o, 1'b0);
      end
      last_data = data_o;
    end
    chk("r_all_done", done, NPKT);
    chk("r_words", sent_words, exp_word);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
